// File: rtl/fmap_bram_arbiter_rr_pkg.sv
// Shared types and helpers for the feature-map BRAM arbiter.
package fmap_bram_arbiter_rr_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_sel_t;

  localparam int VEC_W = 16;

  typedef struct packed {
    logic [VEC_W-1:0] x;
    logic [VEC_W-1:0] y;
  } vec2_t;

  // Row-major linear address; caller truncates to its address width.
  function automatic int unsigned coord_to_addr(vec2_t c, int unsigned img_w);
    return 32'(c.y) * img_w + 32'(c.x);
  endfunction

  function automatic logic coord_in_range(vec2_t c, int unsigned img_w, int unsigned img_h);
    return (32'(c.x) < img_w) && (32'(c.y) < img_h);
  endfunction

endpackage

// File: rtl/fmap_bram_arbiter_rr_if.sv
// Client handshakes plus BRAM port signals of the feature-map arbiter.
// master = clients and BRAM side, slave = the arbiter itself.
interface fmap_bram_arbiter_rr_if #(
  parameter int N_CLIENTS           = 4,
  parameter int BITS_PER_COORDINATE = 8,
  parameter int DATA_W              = 36,
  parameter int ADDR_W              = 10
);
  logic [N_CLIENTS-1:0]                     rd_valid;
  logic [N_CLIENTS-1:0]                     rd_ready;
  logic [N_CLIENTS*BITS_PER_COORDINATE-1:0] rd_x;
  logic [N_CLIENTS*BITS_PER_COORDINATE-1:0] rd_y;
  logic [DATA_W-1:0]                        rdata;
  logic [N_CLIENTS-1:0]                     rdata_valid;
  logic [N_CLIENTS-1:0]                     wr_valid;
  logic [N_CLIENTS-1:0]                     wr_ready;
  logic [N_CLIENTS*BITS_PER_COORDINATE-1:0] wr_x;
  logic [N_CLIENTS*BITS_PER_COORDINATE-1:0] wr_y;
  logic [N_CLIENTS*DATA_W-1:0]              wr_data;
  logic                                     bram_en_a;
  logic [ADDR_W-1:0]                        bram_addr_a;
  logic [DATA_W-1:0]                        bram_dout_a;
  logic                                     bram_en_b;
  logic                                     bram_we_b;
  logic [ADDR_W-1:0]                        bram_addr_b;
  logic [DATA_W-1:0]                        bram_din_b;

  modport master (
    output rd_valid, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_data, bram_dout_a,
    input  rd_ready, rdata, rdata_valid, wr_ready,
    input  bram_en_a, bram_addr_a, bram_en_b, bram_we_b, bram_addr_b, bram_din_b
  );

  modport slave (
    input  rd_valid, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_data, bram_dout_a,
    output rd_ready, rdata, rdata_valid, wr_ready,
    output bram_en_a, bram_addr_a, bram_en_b, bram_we_b, bram_addr_b, bram_din_b
  );
endinterface

// File: rtl/fmap_bram_arbiter_rr_rr_grant.sv
// Rotating-priority grant: first requester at or after ptr_i, wrapping modulo N.
module rr_grant #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((32'(ptr_i) + 32'(i)) % 32'(N));
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fmap_bram_arbiter_rr.sv
// N-client arbiter for the feature-map BRAM (port A read, port B write).
// Optional read-after-write forwarding: define ARB_RAW_BYPASS_EN.
module fmap_bram_arbiter_rr
  import fmap_bram_arbiter_rr_pkg::*;
#(
  parameter  int N_CLIENTS           = 4,
  parameter  int BITS_PER_COORDINATE = 8,
  parameter  int OUT_CHANNELS        = 4,
  parameter  int BITS_PER_NEURON     = 9,
  parameter  int IMG_WIDTH           = 32,
  parameter  int IMG_HEIGHT          = 32,
  parameter  int READ_LATENCY        = 1,
  parameter  int DATA_W              = OUT_CHANNELS * BITS_PER_NEURON,
  parameter  int ADDR_W              = $clog2(IMG_WIDTH * IMG_HEIGHT),
  localparam int IW                  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1,
  localparam int BPC                 = BITS_PER_COORDINATE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arb_mode,
  input  logic [IW-1:0]          owner_sel,
  fmap_bram_arbiter_rr_if.slave  bus
);
  arb_sel_t               mode;
  logic [N_CLIENTS-1:0]   own_mask, rd_req, wr_req, rd_gnt, wr_gnt;
  logic [IW-1:0]          rd_idx, wr_idx, rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                   rd_go, wr_go, rd_inr, wr_inr, wr_we;
  vec2_t                  rd_c, wr_c;
  logic [ADDR_W-1:0]      rd_addr, wr_addr;
  logic [DATA_W-1:0]      wr_word;
  logic [READ_LATENCY-1:0] pv_q, pinr_q;
  logic [IW-1:0]          pidx_q [READ_LATENCY];
  logic [DATA_W-1:0]      rdata_c;
  logic [N_CLIENTS-1:0]   rvalid_c;

  assign mode = arb_sel_t'(arb_mode);

  always_comb begin
    own_mask = '0;
    if (int'(owner_sel) < N_CLIENTS) own_mask[owner_sel] = 1'b1;
  end

  // Grants are held off while reset is asserted so every output reads 0.
  assign rd_req = !rst_n ? '0 : (mode == ARB_FIXED) ? (bus.rd_valid & own_mask) : bus.rd_valid;
  assign wr_req = !rst_n ? '0 : (mode == ARB_FIXED) ? (bus.wr_valid & own_mask) : bus.wr_valid;

  rr_grant #(.N(N_CLIENTS)) u_rd_grant (
    .req_i(rd_req), .ptr_i(rd_ptr_q), .gnt_o(rd_gnt), .idx_o(rd_idx), .any_o(rd_go)
  );

  rr_grant #(.N(N_CLIENTS)) u_wr_grant (
    .req_i(wr_req), .ptr_i(wr_ptr_q), .gnt_o(wr_gnt), .idx_o(wr_idx), .any_o(wr_go)
  );

  always_comb begin
    rd_c   = '0;
    wr_c   = '0;
    rd_c.x = VEC_W'(bus.rd_x[int'(rd_idx)*BPC +: BPC]);
    rd_c.y = VEC_W'(bus.rd_y[int'(rd_idx)*BPC +: BPC]);
    wr_c.x = VEC_W'(bus.wr_x[int'(wr_idx)*BPC +: BPC]);
    wr_c.y = VEC_W'(bus.wr_y[int'(wr_idx)*BPC +: BPC]);
  end

  assign rd_addr = ADDR_W'(coord_to_addr(rd_c, IMG_WIDTH));
  assign wr_addr = ADDR_W'(coord_to_addr(wr_c, IMG_WIDTH));
  assign rd_inr  = coord_in_range(rd_c, IMG_WIDTH, IMG_HEIGHT);
  assign wr_inr  = coord_in_range(wr_c, IMG_WIDTH, IMG_HEIGHT);
  assign wr_word = bus.wr_data[int'(wr_idx)*DATA_W +: DATA_W];
  assign wr_we   = wr_go & wr_inr;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (mode == ARB_RR && rd_go)
      rd_ptr_d = (int'(rd_idx) == N_CLIENTS - 1) ? '0 : rd_idx + IW'(1);
    if (mode == ARB_RR && wr_go)
      wr_ptr_d = (int'(wr_idx) == N_CLIENTS - 1) ? '0 : wr_idx + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      pv_q     <= '0;
      pinr_q   <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pidx_q[k] <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      pv_q[0]   <= rd_go;
      pinr_q[0] <= rd_inr;
      pidx_q[0] <= rd_idx;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pv_q[k]   <= pv_q[k-1];
        pinr_q[k] <= pinr_q[k-1];
        pidx_q[k] <= pidx_q[k-1];
      end
    end
  end

`ifdef ARB_RAW_BYPASS_EN
  logic [ADDR_W-1:0]       paddr_q [READ_LATENCY];
  logic [DATA_W-1:0]       pdata_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] pbyp_q;

  // Each stage watches port B so the youngest matching write is what returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pbyp_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        paddr_q[k] <= '0;
        pdata_q[k] <= '0;
      end
    end else begin
      paddr_q[0] <= rd_addr;
      pbyp_q[0]  <= wr_we & rd_go & rd_inr & (rd_addr == wr_addr);
      pdata_q[0] <= wr_word;
      for (int k = 1; k < READ_LATENCY; k++) begin
        paddr_q[k] <= paddr_q[k-1];
        pbyp_q[k]  <= pbyp_q[k-1] | (wr_we & pv_q[k-1] & pinr_q[k-1] & (paddr_q[k-1] == wr_addr));
        pdata_q[k] <= (wr_we & pv_q[k-1] & pinr_q[k-1] & (paddr_q[k-1] == wr_addr))
                      ? wr_word : pdata_q[k-1];
      end
    end
  end
`endif

  always_comb begin
    rdata_c  = '0;
    rvalid_c = '0;
    if (pv_q[READ_LATENCY-1]) begin
      rvalid_c[pidx_q[READ_LATENCY-1]] = 1'b1;
      if (pinr_q[READ_LATENCY-1]) begin
`ifdef ARB_RAW_BYPASS_EN
        rdata_c = pbyp_q[READ_LATENCY-1] ? pdata_q[READ_LATENCY-1] : bus.bram_dout_a;
`else
        rdata_c = bus.bram_dout_a;
`endif
      end
    end
  end

  assign bus.rd_ready    = rd_gnt;
  assign bus.wr_ready    = wr_gnt;
  assign bus.rdata       = rdata_c;
  assign bus.rdata_valid = rvalid_c;
  assign bus.bram_en_a   = rd_go & rd_inr;
  assign bus.bram_addr_a = rd_go ? rd_addr : '0;
  assign bus.bram_en_b   = wr_we;
  assign bus.bram_we_b   = wr_we;
  assign bus.bram_addr_b = wr_go ? wr_addr : '0;
  assign bus.bram_din_b  = wr_go ? wr_word : '0;

endmodule
